// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// fetch_entry_t carries one instruction word together with the PC it was fetched from.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int WORD_BYTES    = 4;
    localparam int PC_INC        = 4;
    localparam int PC_R15_OFFSET = 8;

    typedef struct packed {
        logic [31:0]             instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [FETCH_ADDR_W-1:0] word_align(input logic [FETCH_ADDR_W-1:0] addr);
        return addr & ~(FETCH_ADDR_W'(WORD_BYTES - 1));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch entries with push, pop and flush; the head is read straight
// from the storage registers so no input ever reaches head combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t       mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi)))
                    mem_reg[gi] <= push_data;
            end
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues word-aligned requests under a credit limit, queues returned words
// with their PCs and hands them to decode; redirects flush the queue and drop stale responses.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_plus8
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    // Wide enough for many back-to-back redirects against a slow memory.
    localparam int DROP_W = 16;

    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [CNT_W-1:0]  outstanding_reg;
    logic [CNT_W-1:0]  outstanding_next;
    logic [DROP_W-1:0] drop_cnt_reg;
    logic [DROP_W-1:0] drop_cnt_next;

    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_take;
    logic              rsp_counted;
    logic              instr_pop;

    fetch_entry_t      data_head;
    fetch_entry_t      data_push;
    logic [CNT_W-1:0]  data_count;
    logic              data_full;
    logic              data_empty;

    fetch_entry_t      pend_head;
    fetch_entry_t      pend_push;
    logic [CNT_W-1:0]  pend_count;
    logic              pend_full;
    logic              pend_empty;

    // Credit covers words already queued plus requests whose responses will be kept.
    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, data_count} + {1'b0, outstanding_reg}) < (CNT_W + 1)'(DEPTH));
    assign imem_addr      = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop    = imem_rsp_valid && (drop_cnt_reg != '0);
    assign rsp_take    = imem_rsp_valid && (drop_cnt_reg == '0) && (outstanding_reg != '0);
    assign rsp_counted = rsp_drop || rsp_take;

    assign instr_valid = !data_empty;
    assign instr_pop   = instr_valid && instr_ready;

    assign data_push = '{instr: imem_rsp_data, pc: pend_head.pc};
    assign pend_push = '{instr: '0, pc: fetch_pc_reg};

    // Dropped responses never had a tracker entry kept: the tracker is flushed on redirect.
    fetch_queue #(.DEPTH(DEPTH)) u_data_q (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_take),
        .push_data (data_push),
        .pop       (instr_pop),
        .flush     (redirect_valid),
        .head      (data_head),
        .count     (data_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    fetch_queue #(.DEPTH(DEPTH)) u_pend_q (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (pend_push),
        .pop       (rsp_take),
        .flush     (redirect_valid),
        .head      (pend_head),
        .count     (pend_count),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    always_comb begin
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        if (redirect_valid) begin
            outstanding_next = '0;
            drop_cnt_next    = drop_cnt_reg + DROP_W'(outstanding_reg) - DROP_W'(rsp_counted);
        end else begin
            case ({req_fire, rsp_take})
                2'b10:   outstanding_next = outstanding_reg + 1'b1;
                2'b01:   outstanding_next = outstanding_reg - 1'b1;
                default: outstanding_next = outstanding_reg;
            endcase
            if (rsp_drop)
                drop_cnt_next = drop_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            if (redirect_valid)
                fetch_pc_reg <= word_align(redirect_pc);
            else if (req_fire)
                fetch_pc_reg <= fetch_pc_reg + ADDR_W'(PC_INC);
        end
    end

    assign instr          = data_head.instr;
    assign instr_pc       = data_head.pc;
    assign instr_pc_plus8 = data_head.pc + ADDR_W'(PC_R15_OFFSET);

    // A response with nothing in flight is a memory protocol error; it is ignored above.
    always_ff @(posedge clk) begin
        if (!reset && imem_rsp_valid)
            assert ((outstanding_reg != '0) || (drop_cnt_reg != '0));
    end

    logic unused_q_status;
    assign unused_q_status = ^{data_full, pend_head.instr, pend_count, pend_full, pend_empty};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: an in-order memory model with programmable latency,
// a per-cycle vector table for streaming/redirect, and hand sequences for corner cases.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus8;

    instr_fetch #(.DEPTH(2), .ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus8 (instr_pc_plus8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        ready;
        logic        rdv;
        logic [31:0] rdpc;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t mq[$];
    vec_t  tbl[13];
    int    lat = 1;
    int    cyc = 0;
    int    passed = 0;
    int    total = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE1A0_5000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Advance one clock; the memory model records fired requests and drives its response.
    task automatic tick();
        logic        fire;
        logic        rst_s;
        logic [31:0] addr_s;
        @(negedge clk);
        fire   = imem_req_valid && imem_req_ready;
        rst_s  = reset;
        addr_s = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        if (rst_s)
            mq.delete();
        else if (fire)
            mq.push_back('{addr: addr_s, due: cyc - 1 + lat});
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
    endtask

    task automatic drive(input logic rdy, input logic rdv, input logic [31:0] rpc);
        instr_ready    = rdy;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [31:0] pc);
        check({name, " valid"}, instr_valid, 1'b1);
        check({name, " pc"}, instr_pc, pc);
        check({name, " instr"}, instr, mem_word(pc));
        check({name, " pc+8"}, instr_pc_plus8, pc + 32'd8);
    endtask

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        //            rdy  rdv  rdpc          rv   addr          iv   pc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h4,     1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h8,     1'b1, 32'h4};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hC,     1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h8};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h10,    1'b1, 32'hC};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h14,    1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h10};
        tbl[9]  = '{1'b1, 1'b1, 32'h203,   1'b0, 32'h0,     1'b1, 32'h14};
        tbl[10] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h200,   1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h204,   1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h200};

        // Reset state while reset is held.
        tick();
        tick();
        #1;
        check("reset req_valid", imem_req_valid, 1'b0);
        check("reset instr_valid", instr_valid, 1'b0);

        // Streaming with 1-cycle memory, then a redirect to an unaligned target.
        lat = 1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].ready, tbl[i].rdv, tbl[i].rdpc);
            check($sformatf("vec%0d req_valid", i), imem_req_valid, tbl[i].exp_rv);
            if (tbl[i].exp_rv)
                check($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].exp_addr);
            check($sformatf("vec%0d instr_valid", i), instr_valid, tbl[i].exp_iv);
            if (tbl[i].exp_iv)
                check_head($sformatf("vec%0d head", i), tbl[i].exp_pc);
            tick();
        end
        $display("vectors done: %0d/%0d", passed, total);

        // Decode stalled: queue fills, requests stop, head held; fetch resumes after the pop.
        lat = 1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(c >= 5, 1'b0, 32'h0);
            if (c >= 2 && c <= 5) begin
                check($sformatf("stall c%0d req_valid", c), imem_req_valid, 1'b0);
                check_head($sformatf("stall c%0d head", c), 32'h0);
            end
            if (c == 6) begin
                check("stall resume req_valid", imem_req_valid, 1'b1);
                check("stall resume addr", imem_addr, 32'h8);
                check_head("stall resume head", 32'h4);
            end
            tick();
        end
        $display("stall sequence done: %0d/%0d", passed, total);

        // 3-cycle memory: redirect with two requests in flight; both late words dropped.
        lat = 3;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c == 2, 32'h100);
            if (c == 2) check("late redir req_valid", imem_req_valid, 1'b0);
            if (c == 3) check("late first addr", imem_addr, 32'h100);
            if (c == 4) check("late second addr", imem_addr, 32'h104);
            if (c >= 3 && c <= 6)
                check($sformatf("late c%0d instr_valid", c), instr_valid, 1'b0);
            if (c == 7) check_head("late c7 head", 32'h100);
            if (c == 8) check_head("late c8 head", 32'h104);
            tick();
        end
        $display("late redirect done: %0d/%0d", passed, total);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c == 5, 32'h300);
            if (c == 5) check_head("same-cycle c5 head", 32'h8);
            if (c == 6) begin
                check("same-cycle c6 instr_valid", instr_valid, 1'b0);
                check("same-cycle c6 req_valid", imem_req_valid, 1'b1);
                check("same-cycle c6 addr", imem_addr, 32'h300);
            end
            if (c == 7) check("same-cycle c7 instr_valid", instr_valid, 1'b0);
            if (c == 8) check_head("same-cycle c8 head", 32'h300);
            tick();
        end
        $display("same-cycle redirect done: %0d/%0d", passed, total);

        // Address wrap at the top of the address space.
        lat = 1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, c == 0, 32'hFFFF_FFFF);
            if (c == 0) check("wrap redir req_valid", imem_req_valid, 1'b0);
            if (c == 1) check("wrap addr top", imem_addr, 32'hFFFF_FFFC);
            if (c == 2) check("wrap addr zero", imem_addr, 32'h0);
            if (c == 3) check_head("wrap head", 32'hFFFF_FFFC);
            tick();
        end
        $display("wrap done: %0d/%0d", passed, total);

        // Reset asserted with the queue full.
        lat = 1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        check_head("midreset full head", 32'h0);
        check("midreset full req_valid", imem_req_valid, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset req_valid held", imem_req_valid, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("midreset instr_valid", instr_valid, 1'b0);
        check("midreset req_valid", imem_req_valid, 1'b1);
        check("midreset addr", imem_addr, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        check("midreset next addr", imem_addr, 32'h4);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        check_head("midreset refill head", 32'h0);
        tick();
        $display("mid-stream reset done: %0d/%0d", passed, total);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
